// File: rtl/ahb_si_arbiter.sv
// rtl/ahb_si_arbiter.sv - per-slave AHB arbiter driving one-hot address- and data-phase selects
// Build option: AHB_ARB_ROUND_ROBIN_EN selects round-robin arbitration (default: fixed priority, lowest index wins)
module ahb_si_arbiter #(
   parameter int CHANNEL_NUM = 4
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   input  logic [CHANNEL_NUM-1:0] hbusreq,
   input  logic                   hready,
   input  logic [1:0]             htrans_cur,
   input  logic                   hmastlock_cur,
   output logic [CHANNEL_NUM-1:0] addr_sel,
   output logic [CHANNEL_NUM-1:0] data_sel,
   output logic                   data_active
);

   localparam logic [1:0] TRANS_BUSY = 2'b01;
   localparam logic [1:0] TRANS_SEQ  = 2'b11;

   logic                   hold;
   logic [CHANNEL_NUM-1:0] grant;

   // Current owner keeps the bus through locked sequences and burst continuations (SEQ/BUSY)
   always_comb begin
      hold = (|addr_sel) &&
             (hmastlock_cur || (htrans_cur == TRANS_SEQ) || (htrans_cur == TRANS_BUSY));
   end

`ifdef AHB_ARB_ROUND_ROBIN_EN
   localparam int PW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] grant_idx;
   logic [PW-1:0] cand;
   logic          found;
   int            idx;

   // Round-robin search: start one past the last granted master, wrap, first requester wins
   always_comb begin
      grant     = '0;
      grant_idx = rr_ptr;
      found     = 1'b0;
      idx       = 0;
      cand      = '0;
      for (int off = 1; off <= CHANNEL_NUM; off++) begin
         idx = int'(rr_ptr) + off;
         if (idx >= CHANNEL_NUM) begin
            idx = idx - CHANNEL_NUM;
         end
         cand = PW'(idx);
         if (!found && hbusreq[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Pointer remembers the most recent fresh grant; held and empty grants leave it alone
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rr_ptr <= PW'(CHANNEL_NUM - 1);
      end else if (hready && !hold && found) begin
         rr_ptr <= grant_idx;
      end
   end
`else
   // Fixed priority: isolate the lowest set request bit
   always_comb begin
      grant = hbusreq & (~hbusreq + CHANNEL_NUM'(1));
   end
`endif

   // Address-phase grant and its one-transfer-delayed data-phase copy; everything stalls on wait states
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_sel    <= '0;
         data_sel    <= '0;
         data_active <= 1'b0;
      end else if (hready) begin
         if (!hold) begin
            addr_sel <= grant;
         end
         data_sel    <= htrans_cur[1] ? addr_sel : '0;
         data_active <= htrans_cur[1] & (|addr_sel);
      end
   end

endmodule

// File: tb/tb_ahb_si_arbiter.sv
// tb/tb_ahb_si_arbiter.sv - self-checking bench for ahb_si_arbiter against a behavioural model
module tb_ahb_si_arbiter;

   localparam int N = 4;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] hbusreq;
   logic         hready;
   logic [1:0]   htrans_cur;
   logic         hmastlock_cur;
   logic [N-1:0] addr_sel;
   logic [N-1:0] data_sel;
   logic         data_active;

   int n_vec;
   int n_fail;

   // model: owner index of address phase, owner of data phase (-1 = none)
   int m_owner;
   int m_downer;
`ifdef AHB_ARB_ROUND_ROBIN_EN
   int m_ptr;
`endif

   logic [N-1:0] dir_a [5];
   logic [N-1:0] dir_d [5];

   ahb_si_arbiter #(.CHANNEL_NUM(N)) dut (
      .HCLK          (clk),
      .HRESETn       (rst_n),
      .hbusreq       (hbusreq),
      .hready        (hready),
      .htrans_cur    (htrans_cur),
      .hmastlock_cur (hmastlock_cur),
      .addr_sel      (addr_sel),
      .data_sel      (data_sel),
      .data_active   (data_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] one;
      one = N'(1);
      return (i < 0) ? '0 : (one << i);
   endfunction

   task automatic model_reset();
      m_owner  = -1;
      m_downer = -1;
`ifdef AHB_ARB_ROUND_ROBIN_EN
      m_ptr    = N - 1;
`endif
   endtask

   task automatic model_edge();
      bit hold;
      int pick;
      if (!hready) return;
      hold = (m_owner >= 0) && (hmastlock_cur || htrans_cur == 2'b11 || htrans_cur == 2'b01);
      m_downer = htrans_cur[1] ? m_owner : -1;
      if (!hold) begin
         pick = -1;
`ifdef AHB_ARB_ROUND_ROBIN_EN
         for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (pick < 0 && hbusreq[i]) pick = i;
         end
         if (pick >= 0) m_ptr = pick;
`else
         for (int i = N - 1; i >= 0; i--) begin
            if (hbusreq[i]) pick = i;
         end
`endif
         m_owner = pick;
      end
   endtask

   task automatic check_model();
      chk("addr_sel", 32'(addr_sel), 32'(oh(m_owner)));
      chk("data_sel", 32'(data_sel), 32'(oh(m_downer)));
      chk("data_active", 32'(data_active), 32'(m_downer >= 0));
      chk("onehot0", 32'($onehot0(addr_sel) && $onehot0(data_sel)), 32'(1));
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      check_model();
   endtask

   task automatic drive(input logic [N-1:0] req, input logic rdy, input logic [1:0] tr, input logic lk);
      hbusreq       = req;
      hready        = rdy;
      htrans_cur    = tr;
      hmastlock_cur = lk;
   endtask

   initial begin
      n_vec  = 0;
      n_fail = 0;
      model_reset();
      drive('0, 1'b1, 2'b00, 1'b0);
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_addr", 32'(addr_sel), 32'(0));
      chk("reset_data", 32'(data_sel), 32'(0));
      chk("reset_active", 32'(data_active), 32'(0));
      drive(4'b1111, 1'b1, 2'b10, 1'b0);
      step();
      #3 rst_n = 1'b1;

      // fairness / priority sequence
`ifdef AHB_ARB_ROUND_ROBIN_EN
      dir_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      dir_d = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      drive(4'b1111, 1'b1, 2'b10, 1'b0);
`else
      dir_a = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
      dir_d = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
      drive(4'b1010, 1'b1, 2'b10, 1'b0);
`endif
      for (int i = 0; i < 5; i++) begin
         step();
         chk("seq_addr", 32'(addr_sel), 32'(dir_a[i]));
         chk("seq_data", 32'(data_sel), 32'(dir_d[i]));
      end

      // wait states freeze everything
      drive(4'b0010, 1'b1, 2'b10, 1'b0);
      step();
      chk("ws_grant", 32'(addr_sel), 32'(4'b0010));
      drive(4'b1111, 1'b0, 2'b10, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("ws_freeze_addr", 32'(addr_sel), 32'(4'b0010));
      end
      hready = 1'b1;
      step();
      chk("ws_release_data", 32'(data_sel), 32'(4'b0010));

      // burst hold
      drive(4'b0100, 1'b1, 2'b10, 1'b0);
      step();
      chk("burst_grant", 32'(addr_sel), 32'(4'b0100));
      drive(4'b1011, 1'b1, 2'b11, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("burst_hold", 32'(addr_sel), 32'(4'b0100));
      end
      htrans_cur = 2'b00;
      step();
      chk("idle_data", 32'(data_sel), 32'(0));
      chk("idle_active", 32'(data_active), 32'(0));
      hbusreq = '0;
      step();
      chk("noreq_addr", 32'(addr_sel), 32'(0));

      // lock hold
      drive(4'b0001, 1'b1, 2'b10, 1'b0);
      step();
      chk("lock_grant", 32'(addr_sel), 32'(4'b0001));
      drive(4'b1110, 1'b1, 2'b10, 1'b1);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("lock_hold", 32'(addr_sel), 32'(4'b0001));
      end
      hmastlock_cur = 1'b0;
      step();
      chk("lock_drop", 32'(addr_sel), 32'(4'b0010));

      // asynchronous reset mid-transfer
      drive(4'b0100, 1'b1, 2'b10, 1'b0);
      step();
      chk("arst_pre", 32'(addr_sel), 32'(4'b0100));
      htrans_cur = 2'b11;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_addr", 32'(addr_sel), 32'(0));
      chk("arst_data", 32'(data_sel), 32'(0));
      chk("arst_active", 32'(data_active), 32'(0));
      model_reset();
      #2 rst_n = 1'b1;

      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         drive(N'($urandom), ($urandom_range(3) != 0), 2'($urandom), ($urandom_range(7) == 0));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
